// File: rtl/fec_cfg_sequencer.sv
// Reconfiguration sequencer for the streaming FEC codec: gates the symbol handshake,
// drains the codec pipeline, streams new coefficients into the cfg port, then resumes.
module fec_cfg_sequencer #(
    parameter int unsigned M            = 3,
    parameter int unsigned WIDTH        = 11,
    parameter int unsigned INDEX_W      = (M * M <= 1) ? 1 : $clog2(M * M),
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_load_dec,
    input  logic                   req_load_enc,
    input  logic [M*M*WIDTH-1:0]   req_decode_flat,
    input  logic [M*M*WIDTH-1:0]   req_encode_flat,
    input  logic                   up_valid,
    output logic                   up_ready,
    output logic                   dn_valid,
    input  logic                   dn_ready,
    input  logic                   mon_out_valid,
    input  logic                   mon_out_ready,
    output logic                   cfg_we,
    output logic                   cfg_select,
    output logic [INDEX_W-1:0]     cfg_index,
    output logic [WIDTH-1:0]       cfg_data,
    output logic                   cfg_done,
    output logic                   busy,
    output logic [CNT_W-1:0]       inflight
);

    localparam int unsigned NENT = M * M;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic                          load_dec_q, load_dec_d;
    logic                          load_enc_q, load_enc_d;
    logic [NENT-1:0][WIDTH-1:0]    dec_q, dec_d;
    logic [NENT-1:0][WIDTH-1:0]    enc_q, enc_d;
    logic                          sel_q, sel_d;
    logic [INDEX_W-1:0]            idx_q, idx_d;
    logic [CNT_W-1:0]              inflight_q, inflight_d;
    logic                          in_fire_c, out_fire_c;

    // Handshakes are only ever let through from the registered IDLE state.
    assign in_fire_c  = !rst && (state_q == IDLE) && up_valid && dn_ready;
    assign out_fire_c = mon_out_valid && mon_out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            load_dec_q <= 1'b0;
            load_enc_q <= 1'b0;
            dec_q      <= '0;
            enc_q      <= '0;
            sel_q      <= 1'b0;
            idx_q      <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            load_dec_q <= load_dec_d;
            load_enc_q <= load_enc_d;
            dec_q      <= dec_d;
            enc_q      <= enc_d;
            sel_q      <= sel_d;
            idx_q      <= idx_d;
            inflight_q <= inflight_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_dec_d = load_dec_q;
        load_enc_d = load_enc_q;
        dec_d      = dec_q;
        enc_d      = enc_q;
        sel_d      = sel_q;
        idx_d      = idx_q;
        req_ready  = 1'b0;
        up_ready   = 1'b0;
        dn_valid   = 1'b0;
        cfg_we     = 1'b0;
        cfg_select = 1'b0;
        cfg_index  = '0;
        cfg_data   = '0;
        cfg_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = !rst;
                up_ready  = !rst && dn_ready;
                dn_valid  = !rst && up_valid;
                if (req_valid) begin
                    load_dec_d = req_load_dec;
                    load_enc_d = req_load_enc;
                    dec_d      = req_decode_flat;
                    enc_d      = req_encode_flat;
                    state_d    = (req_load_dec || req_load_enc) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = LOAD;
                    sel_d   = !load_dec_q;
                    idx_d   = '0;
                end
            end
            LOAD: begin
                cfg_we     = !rst;
                cfg_select = !rst && sel_q;
                cfg_index  = rst ? '0 : idx_q;
                cfg_data   = rst ? '0 : (sel_q ? enc_q[idx_q] : dec_q[idx_q]);
                // Decode entries first, then hop to the encode matrix if enabled.
                if (idx_q == INDEX_W'(NENT - 1)) begin
                    if (!sel_q && load_enc_q) begin
                        sel_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    idx_d = idx_q + INDEX_W'(1);
                end
            end
            DONE: begin
                cfg_done = !rst;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating in-flight tracker; simultaneous in/out leaves it unchanged.
    always_comb begin
        inflight_d = inflight_q;
        if (in_fire_c && !out_fire_c && inflight_q != CNT_W'(MAX_INFLIGHT)) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!in_fire_c && out_fire_c && inflight_q != '0) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(in_fire_c && !out_fire_c && inflight_q == CNT_W'(MAX_INFLIGHT)))
                else $error("fec_cfg_sequencer: inflight overflow");
            assert (!(out_fire_c && !in_fire_c && inflight_q == '0))
                else $error("fec_cfg_sequencer: inflight underflow");
        end
    end

    assign busy     = (state_q != IDLE);
    assign inflight = inflight_q;

endmodule

// File: tb/tb_fec_cfg_sequencer.sv
// Directed self-checking bench for fec_cfg_sequencer.
module tb_fec_cfg_sequencer;

    localparam int unsigned M     = 3;
    localparam int unsigned W     = 11;
    localparam int unsigned IW    = 4;
    localparam int unsigned CW    = 2;
    localparam int unsigned NENT  = M * M;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req_valid, req_ready, req_load_dec, req_load_enc;
    logic [NENT*W-1:0]    req_decode_flat, req_encode_flat;
    logic                 up_valid, up_ready, dn_valid, dn_ready;
    logic                 mon_out_valid, mon_out_ready;
    logic                 cfg_we, cfg_select, cfg_done, busy;
    logic [IW-1:0]        cfg_index;
    logic [W-1:0]         cfg_data;
    logic [CW-1:0]        inflight;

    int checks = 0;
    int errors = 0;

    fec_cfg_sequencer #(.M(M), .WIDTH(W), .MAX_INFLIGHT(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_load_dec(req_load_dec), .req_load_enc(req_load_enc),
        .req_decode_flat(req_decode_flat), .req_encode_flat(req_encode_flat),
        .up_valid(up_valid), .up_ready(up_ready),
        .dn_valid(dn_valid), .dn_ready(dn_ready),
        .mon_out_valid(mon_out_valid), .mon_out_ready(mon_out_ready),
        .cfg_we(cfg_we), .cfg_select(cfg_select), .cfg_index(cfg_index),
        .cfg_data(cfg_data), .cfg_done(cfg_done), .busy(busy), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_load_dec = 1'b0; req_load_enc = 1'b0;
        req_decode_flat = '0; req_encode_flat = '0;
        up_valid = 1'b1; dn_ready = 1'b1; mon_out_valid = 1'b0; mon_out_ready = 1'b0;
        tick(); tick(); #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b exp 0", req_ready); end
        checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL rst_up_ready: got %b exp 0", up_ready); end
        checks++; if (dn_valid !== 1'b0) begin errors++; $display("FAIL rst_dn_valid: got %b exp 0", dn_valid); end
        tick();
        rst = 1'b0; req_valid = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL reset_inflight: got %0d exp 0", inflight); end
        checks++; if ({cfg_we, cfg_select, cfg_index, cfg_data, cfg_done} !== '0) begin
            errors++; $display("FAIL reset_cfg: got we=%b sel=%b idx=%0d data=%0d done=%b exp all 0",
                               cfg_we, cfg_select, cfg_index, cfg_data, cfg_done); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b exp 1", req_ready); end
    endtask

    task automatic test_stream();
        up_valid = 1'b1; dn_ready = 1'b1; #1;
        checks++; if ({dn_valid, up_ready} !== 2'b11) begin errors++; $display("FAIL stream_pass: got dn_valid=%b up_ready=%b exp 1 1", dn_valid, up_ready); end
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL stream_cnt0: got %0d exp 0", inflight); end
        tick(); #1;
        checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL stream_cnt1: got %0d exp 1", inflight); end
        checks++; if (dn_valid !== 1'b1) begin errors++; $display("FAIL stream_dn_valid: got %b exp 1", dn_valid); end
        tick();
        up_valid = 1'b0; dn_ready = 1'b0; #1;
        checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL stream_cnt2: got %0d exp 2", inflight); end
    endtask

    // Encode-only load started with two vectors still inside the codec.
    task automatic test_drain();
        logic [W-1:0] exp_d;
        for (int k = 0; k < int'(NENT); k++) begin
            req_encode_flat[k*W +: W] = W'(100 + k);
            req_decode_flat[k*W +: W] = W'(500 + k);
        end
        req_valid = 1'b1; req_load_dec = 1'b0; req_load_enc = 1'b1; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL drain_accept: got %b exp 1", req_ready); end
        tick();
        req_valid = 1'b0; up_valid = 1'b1; mon_out_valid = 1'b1; mon_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if ({busy, cfg_we, dn_valid, up_ready} !== 4'b1000) begin
                errors++; $display("FAIL drain_hold c%0d: got busy=%b we=%b dn_valid=%b up_ready=%b exp 1 0 0 0",
                                   i, busy, cfg_we, dn_valid, up_ready); end
            checks++; if (inflight !== 2'd2) begin errors++; $display("FAIL drain_cnt c%0d: got %0d exp 2", i, inflight); end
            tick();
        end
        mon_out_ready = 1'b1; #1;
        checks++; if (cfg_we !== 1'b0) begin errors++; $display("FAIL drain_we_c0: got %b exp 0", cfg_we); end
        tick(); #1;
        checks++; if ({inflight, cfg_we} !== {2'd1, 1'b0}) begin errors++; $display("FAIL drain_c1: got cnt=%0d we=%b exp 1 0", inflight, cfg_we); end
        tick();
        mon_out_valid = 1'b0; mon_out_ready = 1'b0; #1;
        checks++; if ({inflight, cfg_we} !== {2'd0, 1'b0}) begin errors++; $display("FAIL drain_c2: got cnt=%0d we=%b exp 0 0", inflight, cfg_we); end
        for (int k = 0; k < int'(NENT); k++) begin
            tick(); #1;
            exp_d = W'(100 + k);
            checks++; if ({cfg_we, cfg_select, cfg_index, cfg_data} !== {1'b1, 1'b1, IW'(k), exp_d}) begin
                errors++; $display("FAIL drain_write k=%0d: got we=%b sel=%b idx=%0d data=%0d exp 1 1 %0d %0d",
                                   k, cfg_we, cfg_select, cfg_index, cfg_data, k, exp_d); end
        end
        tick(); #1;
        checks++; if ({cfg_done, cfg_we} !== 2'b10) begin errors++; $display("FAIL drain_done: got done=%b we=%b exp 1 0", cfg_done, cfg_we); end
        tick();
        up_valid = 1'b0; #1;
        checks++; if ({busy, cfg_done} !== 2'b00) begin errors++; $display("FAIL drain_idle: got busy=%b done=%b exp 0 0", busy, cfg_done); end
    endtask

    // mask = {load_enc, load_dec}; decode entry k = k+1, encode entry k = 2k.
    task automatic test_load(input logic [1:0] mask);
        int           ktot;
        logic         exp_sel;
        int           exp_k;
        logic [W-1:0] exp_d;
        ktot = (mask[0] ? int'(NENT) : 0) + (mask[1] ? int'(NENT) : 0);
        for (int k = 0; k < int'(NENT); k++) begin
            req_decode_flat[k*W +: W] = W'(k + 1);
            req_encode_flat[k*W +: W] = W'(2 * k);
        end
        req_valid = 1'b1; req_load_dec = mask[0]; req_load_enc = mask[1]; #1;
        checks++; if ({req_ready, busy} !== 2'b10) begin errors++; $display("FAIL load%b_accept: got ready=%b busy=%b exp 1 0", mask, req_ready, busy); end
        tick();
        req_valid = 1'b0; up_valid = 1'b1; dn_ready = 1'b1; #1;
        if (ktot != 0) begin
            checks++; if ({busy, up_ready, dn_valid, cfg_we, cfg_done} !== 5'b10000) begin
                errors++; $display("FAIL load%b_drain: got busy=%b up_ready=%b dn_valid=%b we=%b done=%b exp 1 0 0 0 0",
                                   mask, busy, up_ready, dn_valid, cfg_we, cfg_done); end
            for (int i = 0; i < ktot; i++) begin
                tick(); #1;
                exp_sel = !(mask[0] && i < int'(NENT));
                exp_k   = (mask[0] && exp_sel) ? i - int'(NENT) : i;
                exp_d   = exp_sel ? W'(2 * exp_k) : W'(exp_k + 1);
                checks++; if ({cfg_we, cfg_select, cfg_index, cfg_data, up_ready, cfg_done} !==
                              {1'b1, exp_sel, IW'(exp_k), exp_d, 1'b0, 1'b0}) begin
                    errors++; $display("FAIL load%b_write i=%0d: got we=%b sel=%b idx=%0d data=%0d up_ready=%b done=%b exp 1 %b %0d %0d 0 0",
                                       mask, i, cfg_we, cfg_select, cfg_index, cfg_data, up_ready, cfg_done,
                                       exp_sel, exp_k, exp_d); end
            end
            tick(); #1;
        end
        checks++; if ({cfg_done, cfg_we, up_ready, busy} !== 4'b1001) begin
            errors++; $display("FAIL load%b_done: got done=%b we=%b up_ready=%b busy=%b exp 1 0 0 1",
                               mask, cfg_done, cfg_we, up_ready, busy); end
        tick();
        up_valid = 1'b0; dn_ready = 1'b0; #1;
        checks++; if ({busy, cfg_done, req_ready} !== 3'b001) begin
            errors++; $display("FAIL load%b_idle: got busy=%b done=%b ready=%b exp 0 0 1", mask, busy, cfg_done, req_ready); end
    endtask

    task automatic test_same_cycle();
        up_valid = 1'b1; dn_ready = 1'b1; #1;
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL same_start: got %0d exp 0", inflight); end
        tick();
        mon_out_valid = 1'b1; mon_out_ready = 1'b1; #1;
        checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL same_pre: got %0d exp 1", inflight); end
        tick();
        up_valid = 1'b0; dn_ready = 1'b0; #1;
        checks++; if (inflight !== 2'd1) begin errors++; $display("FAIL same_both: got %0d exp 1", inflight); end
        tick();
        mon_out_valid = 1'b0; mon_out_ready = 1'b0; #1;
        checks++; if (inflight !== 2'd0) begin errors++; $display("FAIL same_drain: got %0d exp 0", inflight); end
    endtask

    // Decode-only requests held high: one accept per 12-cycle round trip.
    task automatic test_back_to_back();
        int accepts = 0, dones = 0, writes = 0, bad = 0, waited = 0;
        req_valid = 1'b1; req_load_dec = 1'b1; req_load_enc = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (req_ready) begin
                accepts++;
                if (busy) bad++;
            end
            if (cfg_done) dones++;
            if (cfg_we) writes++;
            tick();
        end
        req_valid = 1'b0;
        checks++; if (accepts != 3) begin errors++; $display("FAIL b2b_accepts: got %0d exp 3", accepts); end
        checks++; if (dones != 2) begin errors++; $display("FAIL b2b_dones: got %0d exp 2", dones); end
        checks++; if (writes != 22) begin errors++; $display("FAIL b2b_writes: got %0d exp 22", writes); end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_ready_busy: got %0d exp 0", bad); end
        #1;
        while (busy === 1'b1 && waited < 50) begin
            tick(); #1;
            waited++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_timeout: got busy=%b exp 0", busy); end
    endtask

    task automatic test_reset_mid_load();
        int stray = 0;
        req_valid = 1'b1; req_load_dec = 1'b1; req_load_enc = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        checks++; if ({cfg_we, cfg_index} !== {1'b1, IW'(3)}) begin
            errors++; $display("FAIL rml_4th: got we=%b idx=%0d exp 1 3", cfg_we, cfg_index); end
        tick();
        rst = 1'b1; #1;
        checks++; if ({cfg_we, req_ready} !== 2'b00) begin errors++; $display("FAIL rml_during: got we=%b ready=%b exp 0 0", cfg_we, req_ready); end
        tick();
        rst = 1'b0; #1;
        checks++; if ({cfg_we, busy, inflight, cfg_done} !== 5'b0) begin
            errors++; $display("FAIL rml_after: got we=%b busy=%b cnt=%0d done=%b exp 0 0 0 0", cfg_we, busy, inflight, cfg_done); end
        for (int i = 0; i < 25; i++) begin
            if (cfg_we || cfg_done) stray++;
            tick(); #1;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL rml_stray: got %0d exp 0", stray); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drain();
        test_load(2'b11);
        test_load(2'b01);
        test_load(2'b00);
        test_same_cycle();
        test_back_to_back();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fec_cfg_sequencer.md
Name: fec_cfg_sequencer

Overview:
Reconfiguration controller for the streaming FEC codec. It gates the codec's symbol input handshake and drains in-flight symbols. It then writes a new decode and/or encode coefficient matrix through the codec's cfg_we/cfg_select/cfg_index/cfg_data port, one entry per cycle, and resumes the stream. Coefficients are never rewritten while a symbol is inside the codec pipeline.

Parameters:
M, 3, matrix dimension (symbols per vector)
WIDTH, 11, coefficient width in bits
INDEX_W, (M*M <= 1) ? 1 : $clog2(M*M), width of cfg_index
MAX_INFLIGHT, 2, codec pipeline capacity in symbol vectors
CNT_W, $clog2(MAX_INFLIGHT+1), in-flight counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  reconfiguration request valid
req_ready  out  1  request accepted when high with req_valid
req_load_dec  in  1  load the decode matrix
req_load_enc  in  1  load the encode matrix
req_decode_flat  in  M*M*WIDTH  decode coefficients, entry k at [k*WIDTH +: WIDTH], k = row*M+col
req_encode_flat  in  M*M*WIDTH  encode coefficients, same packing
up_valid  in  1  symbol source valid
up_ready  out  1  symbol source ready
dn_valid  out  1  to codec symbols_valid
dn_ready  in  1  from codec symbols_ready
mon_out_valid  in  1  codec symbols_out_valid (monitor)
mon_out_ready  in  1  codec symbols_out_ready (monitor)
cfg_we  out  1  coefficient write strobe
cfg_select  out  1  0 = decode matrix, 1 = encode matrix
cfg_index  out  INDEX_W  entry index row*M+col
cfg_data  out  WIDTH  coefficient value
cfg_done  out  1  one-cycle pulse when reconfiguration completes
busy  out  1  state != IDLE
inflight  out  CNT_W  symbol vectors currently inside the codec

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. Single clock domain. Symbol data does not pass through this block; only handshakes pass through.
- States:
  - IDLE: dn_valid = up_valid, up_ready = dn_ready, req_ready = 1.
  - DRAIN, LOAD, DONE: dn_valid = 0, up_ready = 0, req_ready = 0.
- All gating is decoded from registered state. There is no combinational path from req_* to dn_valid/up_ready.
- Request accept (IDLE, req_valid & req_ready): capture the mask and both matrices into holding registers.
  - Mask != 00: next state DRAIN.
  - Mask == 00: next state DONE.
  - A symbol handshake on the accept cycle itself is legal and is counted.
- DRAIN: go to LOAD when the registered inflight == 0. Otherwise stay in DRAIN with no time limit.
- LOAD: a write pointer walks the enabled entries in a fixed order:
  - decode entries k = 0..M*M-1 with cfg_select = 0 (if load_dec), then
  - encode entries k = 0..M*M-1 with cfg_select = 1 (if load_enc).
- In LOAD, cfg_we = 1 every cycle, with cfg_index = k and cfg_data = captured entry k. There is no backpressure on the cfg port. After the last enabled entry, go to DONE.
- Outside LOAD: cfg_we = 0, and cfg_select/cfg_index/cfg_data = 0.
- DONE: cfg_done = 1 for exactly one cycle, then IDLE. The stream resumes in the IDLE cycle.
- Latency (accept at cycle T, pipeline empty, K enabled entries): DRAIN at T+1, writes on T+2 .. T+K+1, DONE at T+K+2, IDLE at T+K+3. With mask 00: DONE at T+1, IDLE at T+2.
- inflight counter:
  - +1 on dn_valid & dn_ready.
  - -1 on mon_out_valid & mon_out_ready.
  - Both on the same cycle: unchanged.
  - Overflow past MAX_INFLIGHT or underflow below 0: the counter holds and a simulation assertion fires.
- req_valid held during busy is ignored until IDLE. The request is then accepted with the current req_* values.
- Reset values: state IDLE, inflight 0, cfg_we/cfg_select/cfg_index/cfg_data 0, cfg_done 0, busy 0, holding registers 0.
- While rst = 1: req_ready = 0, up_ready = 0, dn_valid = 0.
- Reset mid-operation aborts with no further writes. A partially loaded matrix is left in the codec, so the system resets the codec together with this block.

Test Plan:
- Reset, then up_valid = 1, dn_ready = 1 for 2 cycles, mon_out_valid = 0 -> dn_valid = 1, up_ready = 1, inflight = 1 then 2.
- Empty pipeline, request at T with mask 11, decode entry k = k+1, encode entry k = 2k -> 18 cfg_we cycles T+2..T+19: indices 0..8 with select 0 and data 1..9, then 0..8 with select 1 and data 0,2..16; cfg_done only at T+20; up_ready = 0 from T+1 to T+20.
- inflight = 2, request, mon_out_ready low for 5 cycles -> state stays DRAIN, cfg_we = 0, dn_valid = 0; two output fires at C and C+1 -> first cfg_we at C+3.
- Mask 01 -> 9 writes, all select 0. Mask 00 -> no cfg_we, cfg_done at T+1, busy low at T+2.
- inflight = 1 with an input fire and an output fire on the same cycle -> inflight stays 1. req_valid held high through busy -> exactly one accept per IDLE entry.
- rst = 1 during LOAD after the 4th write -> next cycle cfg_we = 0, busy = 0, inflight = 0, cfg_done never pulses.
